// File: rtl/alu_result_bcd.sv
// Sequential double-dabble converter: ALU result f -> three BCD digits, one bit per clock.
// Optional macro SIGNED_DISPLAY_EN: treat result as two's complement and present |f| with a neg flag.
module alu_result_bcd #(
   parameter bit AUTO_START = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] result,
   output logic       busy,
   output logic       done,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       neg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [11:0] scratch_q, scratch_d;
   logic [7:0]  operand_q, operand_d;
   logic [7:0]  last_q, last_d;
   logic        neg_pend_q, neg_pend_d;
   logic [3:0]  hund_q, hund_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;
   logic        neg_q, neg_d;

   logic        trigger;
   logic        sign_w;
   logic [7:0]  mag_w;
   logic [11:0] adj;
   logic [19:0] shifted;

`ifdef SIGNED_DISPLAY_EN
   assign sign_w = result[7];
   assign mag_w  = result[7] ? 8'(~result + 8'd1) : result;
`else
   assign sign_w = 1'b0;
   assign mag_w  = result;
`endif

   assign trigger = start | (AUTO_START & (result != last_q));

   // Add-3 correction on every BCD nibble before the shift.
   always_comb begin
      adj = scratch_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
      shifted = {adj, operand_q} << 1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      scratch_d  = scratch_q;
      operand_d  = operand_q;
      last_d     = last_q;
      neg_pend_d = neg_pend_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      neg_d      = neg_q;
      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d    = S_SHIFT;
               cnt_d      = 3'd7;
               scratch_d  = '0;
               operand_d  = mag_w;
               last_d     = result;
               neg_pend_d = sign_w;
            end
         end
         S_SHIFT: begin
            scratch_d = shifted[19:8];
            operand_d = shifted[7:0];
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
               state_d = S_DONE;
               hund_d  = shifted[19:16];
               tens_d  = shifted[15:12];
               ones_d  = shifted[11:8];
               neg_d   = neg_pend_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         scratch_q  <= '0;
         operand_q  <= '0;
         last_q     <= '0;
         neg_pend_q <= 1'b0;
         hund_q     <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         neg_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scratch_q  <= scratch_d;
         operand_q  <= operand_d;
         last_q     <= last_d;
         neg_pend_q <= neg_pend_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         neg_q      <= neg_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign hundreds = hund_q;
   assign tens     = tens_q;
   assign ones     = ones_q;
   assign neg      = neg_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd: manual-start instance plus an AUTO_START=1 instance.
module tb_alu_result_bcd;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] result;
   logic       busy, done, neg;
   logic [3:0] hundreds, tens, ones;

   logic       start_a;
   logic [7:0] result_a;
   logic       busy_a, done_a, neg_a;
   logic [3:0] hundreds_a, tens_a, ones_a;

   int errors = 0;
   int checks = 0;
   logic [12:0] exp_q;   // {neg, h, t, o} currently presented by the manual instance

   always #5 clk = ~clk;

   alu_result_bcd #(.AUTO_START(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .result(result),
      .busy(busy), .done(done), .hundreds(hundreds), .tens(tens),
      .ones(ones), .neg(neg)
   );

   alu_result_bcd #(.AUTO_START(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .result(result_a),
      .busy(busy_a), .done(done_a), .hundreds(hundreds_a), .tens(tens_a),
      .ones(ones_a), .neg(neg_a)
   );

   // Decimal reference: {neg, hundreds, tens, ones} from plain arithmetic.
   function automatic logic [12:0] ref_bcd(input logic [7:0] r);
      int v;
      logic n;
      v = int'(r);
      n = 1'b0;
`ifdef SIGNED_DISPLAY_EN
      if (v >= 128) begin
         v = 256 - v;
         n = 1'b1;
      end
`endif
      return {n, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; result = 8'h00;
      start_a = 1'b0; result_a = 8'h00;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, neg, hundreds, tens, ones} !== 15'd0) begin
         errors++;
         $display("FAIL reset_main: got busy=%b done=%b neg=%b digits=%h%h%h, want all 0",
                  busy, done, neg, hundreds, tens, ones);
      end
      checks++;
      if ({busy_a, done_a, neg_a, hundreds_a, tens_a, ones_a} !== 15'd0) begin
         errors++;
         $display("FAIL reset_auto: got busy=%b done=%b digits=%h%h%h, want all 0",
                  busy_a, done_a, hundreds_a, tens_a, ones_a);
      end
      exp_q = '0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   // Fixed corner values then random ones; checks timing, capture isolation and digit hold.
   task automatic test_conversions;
      logic [7:0] vals[$];
      logic [12:0] nexp;
      vals = '{8'hFF, 8'h00, 8'h2A, 8'hC8, 8'hF9, 8'h80, 8'h7F, 8'h01, 8'h64, 8'h63};
      for (int i = 0; i < 20; i++) vals.push_back(8'($urandom_range(0, 255)));
      foreach (vals[j]) begin
         nexp = ref_bcd(vals[j]);
         result = vals[j];
         start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL conv_start[%h]: got busy=%b done=%b, want 1 0", vals[j], busy, done);
         end
         for (int k = 1; k <= 8; k++) begin
            if (k == 2) result = 8'($urandom_range(0, 255));
            tick();
            if (k < 8) begin
               checks++;
               if (busy !== 1'b1 || done !== 1'b0 ||
                   {neg, hundreds, tens, ones} !== exp_q) begin
                  errors++;
                  $display("FAIL conv_hold[%h] cyc %0d: got busy=%b done=%b out=%h, want 1 0 %h",
                           vals[j], k, busy, done, {neg, hundreds, tens, ones}, exp_q);
               end
            end else begin
               checks++;
               if (busy !== 1'b1 || done !== 1'b1 ||
                   {neg, hundreds, tens, ones} !== nexp) begin
                  errors++;
                  $display("FAIL conv_done[%h]: got busy=%b done=%b out=%h, want 1 1 %h",
                           vals[j], busy, done, {neg, hundreds, tens, ones}, nexp);
               end
            end
         end
         exp_q = nexp;
         tick();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || {neg, hundreds, tens, ones} !== exp_q) begin
            errors++;
            $display("FAIL conv_end[%h]: got busy=%b done=%b out=%h, want 0 0 %h",
                     vals[j], busy, done, {neg, hundreds, tens, ones}, exp_q);
         end
      end
   endtask

   task automatic test_start_ignored;
      int ndone;
      logic [12:0] nexp;
      nexp = ref_bcd(8'h63);
      ndone = 0;
      result = 8'h63;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) begin result = 8'h07; start = 1'b1; end
         if (k == 4) start = 1'b0;
         tick();
         if (done === 1'b1) ndone++;
         checks++;
         if (busy !== (k <= 8) || done !== (k == 8)) begin
            errors++;
            $display("FAIL ignore_timing cyc %0d: got busy=%b done=%b, want %b %b",
                     k, busy, done, (k <= 8), (k == 8));
         end
      end
      checks++;
      if (ndone != 1 || {neg, hundreds, tens, ones} !== nexp) begin
         errors++;
         $display("FAIL ignore_result: got dones=%0d out=%h, want 1 %h",
                  ndone, {neg, hundreds, tens, ones}, nexp);
      end
      exp_q = nexp;
   endtask

   task automatic test_reset_abort;
      int ndone;
      logic [12:0] nexp;
      nexp = ref_bcd(8'hC8);
      ndone = 0;
      result = 8'hC8;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, neg, hundreds, tens, ones} !== 15'd0) begin
         errors++;
         $display("FAIL abort_clear: got busy=%b done=%b out=%h, want all 0",
                  busy, done, {neg, hundreds, tens, ones});
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d active cycles, want 0", ndone);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      checks++;
      if (done !== 1'b1 || {neg, hundreds, tens, ones} !== nexp) begin
         errors++;
         $display("FAIL abort_restart: got done=%b out=%h, want 1 %h",
                  done, {neg, hundreds, tens, ones}, nexp);
      end
      exp_q = nexp;
      tick();
   endtask

   task automatic test_back_to_back;
      result = 8'hFF;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 34; c++) begin
         tick();
         checks++;
         if (done !== ((c % 10) == 8)) begin
            errors++;
            $display("FAIL b2b_done cyc %0d: got %b, want %b", c, done, ((c % 10) == 8));
         end
      end
      start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      exp_q = ref_bcd(8'hFF);
      checks++;
      if (busy !== 1'b0 || {neg, hundreds, tens, ones} !== exp_q) begin
         errors++;
         $display("FAIL b2b_end: got busy=%b out=%h, want 0 %h",
                  busy, {neg, hundreds, tens, ones}, exp_q);
      end
   endtask

   task automatic test_auto_start;
      int ndone;
      int waited;
      logic [7:0] v;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL auto_zero: got %0d active cycles with result=0, want 0", ndone);
      end
      for (int r = 0; r < 4; r++) begin
         v = (r == 0) ? 8'h0C : 8'($urandom_range(1, 255));
         if (r > 0 && v == result_a) v = v ^ 8'h01;
         result_a = v;
         waited = 0;
         while (done_a !== 1'b1 && waited < 20) begin
            tick();
            waited++;
         end
         checks++;
         if (done_a !== 1'b1 || {neg_a, hundreds_a, tens_a, ones_a} !== ref_bcd(v)) begin
            errors++;
            $display("FAIL auto_conv[%h]: got done=%b out=%h after %0d cycles, want 1 %h",
                     v, done_a, {neg_a, hundreds_a, tens_a, ones_a}, waited, ref_bcd(v));
         end
         ndone = 0;
         for (int k = 0; k < 20; k++) begin
            tick();
            if (done_a === 1'b1) ndone++;
         end
         checks++;
         if (ndone != 0) begin
            errors++;
            $display("FAIL auto_hold[%h]: got %0d extra dones, want 0", v, ndone);
         end
      end
   endtask

   initial begin
      test_reset();
      test_conversions();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_auto_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
- Downstream stage of the 4-bit ALU; consumes its 8-bit result f.
- Converts f to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Feeds the display driver through a start/busy/done handshake.
- Holds the last converted value stable between conversions.

Parameters:
- AUTO_START, 0: when 1, an internal start is generated whenever result differs from the last captured value while IDLE. When 0, only the start port triggers a conversion.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of result; sampled only in IDLE.
- result  input  8  ALU output f.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when new digits are valid.
- hundreds  output  4  BCD hundreds digit, 0..2.
- tens  output  4  BCD tens digit, 0..9.
- ones  output  4  BCD ones digit, 0..9.
- neg  output  1  sign flag; 0 unless SIGNED_DISPLAY_EN is defined.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hundreds=tens=ones=0, neg=0; shift register, counter and last-captured value cleared. Reset has priority over every other event.
- States:
  - IDLE -> SHIFT on the edge where the trigger is high. Trigger is start, or the auto condition when AUTO_START=1.
  - SHIFT: runs 8 cycles; bit counter counts 7 down to 0. Then -> DONE.
  - DONE: lasts 1 cycle, then -> IDLE.
- Capture: at the IDLE->SHIFT edge, result is latched into an internal 8-bit operand and into the last-captured register. Later changes on result do not affect the running conversion.
- Each SHIFT cycle:
  - Each 4-bit BCD nibble of the 12-bit scratch that is >=5 gets +3.
  - Then {scratch, operand} shifts left by 1.
- Latency: start sampled at edge 0; busy=1 from edge 0 through edge 8. At edge 8, hundreds/tens/ones/neg update and done=1 for exactly one cycle. busy=0 from edge 9.
- Outputs change only on the done edge. Otherwise they hold the previous value.
- start while busy, or in DONE, is ignored; no queuing. start held continuously gives back-to-back conversions every 10 cycles.
- Reset mid-conversion: aborts the conversion, returns to IDLE, outputs go to 0, and no done pulse is produced.
- Range: unsigned 0..255, so hundreds never exceeds 2.
- AUTO_START=1: result compared against the last-captured value only in IDLE. The first conversion after reset fires when result != 0. An explicit start also triggers.

Optional Feature:
- Macro SIGNED_DISPLAY_EN.
- Defined:
  - result is treated as two's complement. If result[7]=1, the operand latched at capture is the 8-bit negation and neg=1 is presented with the digits at done; otherwise neg=0.
  - 0x80 converts to magnitude 128, neg=1.
  - Covers the ALU subtract path (e.g. 2-9 = 0xF9).
- Not defined:
  - Unsigned conversion only; neg tied 0; no negation logic is synthesised.

Test Plan:
- reset, then start=1 for 1 cycle with result=0xFF -> busy high for 9 cycles; done pulse at edge 8; hundreds=2, tens=5, ones=5, neg=0.
- result=0x00, start -> done; digits 0,0,0. Then result=0x2A (6*7=42), start -> 0,4,2. Digits hold at 0,0,0 until the second done.
- start at 0x63, change result to 0x07 and pulse start mid-conversion -> single done; digits 0,9,9; the second start is ignored; busy timing unchanged.
- start at 0xC8, assert reset at cycle 4 -> no done pulse; all outputs 0; IDLE. A fresh start with 0xC8 -> 2,0,0.
- SIGNED_DISPLAY_EN defined: result=0xF9 -> neg=1, 0,0,7. result=0x80 -> neg=1, 1,2,8. Not defined: 0xF9 -> neg=0, 2,4,9.
- AUTO_START=1, start tied 0: result steps 0x00 -> 0x0C -> conversion fires automatically; digits 0,1,2. Result held constant -> no further done pulses.
